// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: word-addressed PC, program-loadable instruction
// memory with combinational read, and a registered IF/ID pair.
module instruction_fetch_stage #(
  parameter int             len       = 32,
  parameter int             depth     = 2048,
  parameter int             addr_w    = $clog2(depth),
  parameter logic [len-1:0] NOP_WORD  = 32'h00000000,
  parameter logic [len-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_enable,
  input  logic              in_stall,
  input  logic              in_pc_src,
  input  logic [len-1:0]    in_pc_jump,
  input  logic              in_flush,
  input  logic              in_wr_en,
  input  logic [addr_w-1:0] in_wr_addr,
  input  logic [len-1:0]    in_wr_data,
  output logic [len-1:0]    out_instruction,
  output logic [len-1:0]    out_pc_jump,
  output logic [len-1:0]    out_pc,
  output logic              out_valid,
  output logic              out_halted
);

  logic [len-1:0] mem [depth];
  logic [len-1:0] pc_inc;
  logic [len-1:0] fetch_word;
  logic           fetch_halt;

  assign pc_inc     = out_pc + 1'b1;
  assign fetch_word = mem[out_pc[addr_w-1:0]];
  assign fetch_halt = (fetch_word == HALT_WORD);

  // Program load is independent of reset/enable; a same-edge fetch sees the old word.
  always_ff @(posedge clk) begin
    if (in_wr_en) mem[in_wr_addr] <= in_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_pc          <= '0;
      out_instruction <= NOP_WORD;
      out_pc_jump     <= '0;
      out_valid       <= 1'b0;
      out_halted      <= 1'b0;
    end else if (in_enable) begin
      if (in_pc_src) begin
        out_pc          <= in_pc_jump;
        out_instruction <= NOP_WORD;
        out_valid       <= 1'b0;
        out_halted      <= 1'b0;
      end else if (in_flush) begin
        if (!out_halted) out_pc <= pc_inc;
        out_instruction <= NOP_WORD;
        out_valid       <= 1'b0;
      end else if (!in_stall) begin
        if (out_halted) begin
          out_instruction <= NOP_WORD;
          out_valid       <= 1'b0;
        end else begin
          out_instruction <= fetch_word;
          out_pc_jump     <= pc_inc;
          out_valid       <= 1'b1;
          // A fetched HALT parks the PC on itself until redirected.
          if (fetch_halt) out_halted <= 1'b1;
          else            out_pc     <= pc_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus randomized
// traffic against a behavioural model of the fetch rules.
module tb_instruction_fetch_stage;
  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0, HALT = 32'hFFFFFFFF;

  logic clk = 0, reset = 1, en = 0, stall = 0, pc_src = 0, flush = 0, wr_en = 0;
  logic [31:0] jump = 0, wr_data = 0;
  logic [5:0] wr_addr = 0;
  logic [31:0] ins, pcj, pc;
  logic valid, halted;
  int total = 0, bad = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc = 0, m_ins = 0, m_pcj = 0;
  logic m_valid = 0, m_halt = 0;

  instruction_fetch_stage #(.depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_enable(en), .in_stall(stall), .in_pc_src(pc_src),
    .in_pc_jump(jump), .in_flush(flush), .in_wr_en(wr_en), .in_wr_addr(wr_addr),
    .in_wr_data(wr_data), .out_instruction(ins), .out_pc_jump(pcj), .out_pc(pc),
    .out_valid(valid), .out_halted(halted));

  always #5 clk = ~clk;

  // Advance one clock, applying the fetch rules to the model first.
  task automatic tick();
    logic [31:0] f;
    f = m_mem[m_pc % DEPTH];
    if (reset) begin
      m_pc = 0; m_ins = NOP; m_pcj = 0; m_valid = 0; m_halt = 0;
    end else if (en) begin
      if (pc_src) begin
        m_pc = jump; m_ins = NOP; m_valid = 0; m_halt = 0;
      end else if (flush) begin
        if (!m_halt) m_pc = m_pc + 1;
        m_ins = NOP; m_valid = 0;
      end else if (!stall) begin
        if (m_halt) begin
          m_ins = NOP; m_valid = 0;
        end else begin
          m_ins = f; m_pcj = m_pc + 1; m_valid = 1;
          if (f == HALT) m_halt = 1; else m_pc = m_pc + 1;
        end
      end
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    reset = 0; en = 1; stall = 0; pc_src = 0; flush = 0; wr_en = 0;
  endtask

  task automatic do_reset();
    quiet(); reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1; wr_addr = 6'(i);
      wr_data = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : (i == 2) ? 32'h33 : (i == 3) ? HALT : 32'h1000 + 32'(i);
      tick();
    end
    wr_en = 0;
    total++; if (pc !== 0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
    total++; if (ins !== NOP) begin bad++; $display("FAIL reset_ins got=%h exp=%h", ins, NOP); end
    total++; if (pcj !== 0) begin bad++; $display("FAIL reset_pcj got=%h exp=0", pcj); end
    total++; if (valid !== 0 || halted !== 0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", valid, halted); end
  endtask

  task automatic test_program();
    logic [31:0] exp_ins [4];
    exp_ins[0] = 32'h11; exp_ins[1] = 32'h22; exp_ins[2] = 32'h33; exp_ins[3] = HALT;
    quiet();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (ins !== exp_ins[i] || pcj !== 32'(i + 1) || valid !== 1)
        begin bad++; $display("FAIL prog_%0d got=%h/%h/%b exp=%h/%h/1", i, ins, pcj, valid, exp_ins[i], i + 1); end
    end
    total++; if (halted !== 1 || pc !== 3) begin bad++; $display("FAIL prog_halt got=%b/%h exp=1/3", halted, pc); end
    tick();
    total++; if (halted !== 1 || pc !== 3 || valid !== 0 || ins !== NOP)
      begin bad++; $display("FAIL prog_parked got=%b/%h/%b/%h exp=1/3/0/0", halted, pc, valid, ins); end
  endtask

  task automatic test_halt_resume();
    pc_src = 1; jump = 0; tick(); pc_src = 0;
    total++; if (halted !== 0 || pc !== 0) begin bad++; $display("FAIL resume_redirect got=%b/%h exp=0/0", halted, pc); end
    tick();
    total++; if (ins !== 32'h11 || valid !== 1) begin bad++; $display("FAIL resume_fetch got=%h/%b exp=11/1", ins, valid); end
  endtask

  task automatic test_stall();
    do_reset(); tick();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (ins !== 32'h11 || pc !== 1) begin bad++; $display("FAIL stall_%0d got=%h/%h exp=11/1", i, ins, pc); end
    end
    stall = 0; tick();
    total++; if (ins !== 32'h22 || pc !== 2) begin bad++; $display("FAIL stall_release got=%h/%h exp=22/2", ins, pc); end
  endtask

  task automatic test_redirect_stall();
    pc_src = 1; stall = 1; jump = 32'h40; tick(); pc_src = 0; stall = 0;
    total++; if (pc !== 32'h40 || valid !== 0 || ins !== NOP)
      begin bad++; $display("FAIL redirect_stall got=%h/%b/%h exp=40/0/0", pc, valid, ins); end
  endtask

  task automatic test_flush_halt();
    do_reset(); tick(); tick(); tick();
    flush = 1; tick(); flush = 0;
    total++; if (pc !== 4 || halted !== 0 || valid !== 0)
      begin bad++; $display("FAIL flush_halt got=%h/%b/%b exp=4/0/0", pc, halted, valid); end
  endtask

  task automatic test_write_fetch();
    pc_src = 1; jump = 5; tick(); pc_src = 0;
    wr_en = 1; wr_addr = 5; wr_data = 32'h99; tick(); wr_en = 0;
    total++; if (ins !== 32'h1005 || valid !== 1) begin bad++; $display("FAIL wr_old got=%h exp=1005", ins); end
    pc_src = 1; jump = 5; tick(); pc_src = 0; tick();
    total++; if (ins !== 32'h99) begin bad++; $display("FAIL wr_new got=%h exp=99", ins); end
  endtask

  task automatic test_enable();
    logic [31:0] s_pc, s_ins, s_pcj;
    logic s_v, s_h;
    s_pc = m_pc; s_ins = m_ins; s_pcj = m_pcj; s_v = m_valid; s_h = m_halt;
    en = 0; pc_src = 1; flush = 1; jump = 32'h7;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc !== s_pc || ins !== s_ins || pcj !== s_pcj || valid !== s_v || halted !== s_h)
        begin bad++; $display("FAIL enable_hold_%0d got=%h/%h/%h/%b%b exp=%h/%h/%h/%b%b", i, pc, ins, pcj, valid, halted, s_pc, s_ins, s_pcj, s_v, s_h); end
    end
    quiet();
  endtask

  task automatic test_wrap();
    pc_src = 1; jump = 32'hFFFFFFFF; tick(); pc_src = 0;
    total++; if (pc !== 32'hFFFFFFFF) begin bad++; $display("FAIL wrap_set got=%h exp=ffffffff", pc); end
    tick();
    total++; if (pc !== 0 || pcj !== 0 || ins !== 32'h103F)
      begin bad++; $display("FAIL wrap got=%h/%h/%h exp=0/0/103f", pc, pcj, ins); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset  = ($urandom_range(0, 49) == 0);
      en     = ($urandom_range(0, 9) != 0);
      stall  = ($urandom_range(0, 4) == 0);
      pc_src = ($urandom_range(0, 9) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      jump   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 70));
      wr_en  = ($urandom_range(0, 3) == 0);
      wr_addr = 6'($urandom_range(0, DEPTH - 1));
      wr_data = ($urandom_range(0, 5) == 0) ? HALT : $urandom;
      tick();
      total++; if (pc !== m_pc || ins !== m_ins || pcj !== m_pcj || valid !== m_valid || halted !== m_halt)
        begin bad++; $display("FAIL rand_%0d got=%h/%h/%h/%b%b exp=%h/%h/%h/%b%b", n, pc, ins, pcj, valid, halted, m_pc, m_ins, m_pcj, m_valid, m_halt); end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_program();
    test_halt_resume();
    test_stall();
    test_redirect_stall();
    test_flush_halt();
    test_write_fetch();
    test_enable();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- len, 32, data and PC width in bits.
- depth, 2048, instruction memory depth in words.
- addr_w, clog2(depth), memory index width.
- NOP_WORD, 32'h00000000, bubble inserted on squash.
- HALT_WORD, 32'hFFFFFFFF, instruction that stops fetch.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high.
- in_enable, in, 1, global run/step enable from the debug unit.
- in_stall, in, 1, hazard stall: hold PC and IF/ID.
- in_pc_src, in, 1, taken branch or jump redirect.
- in_pc_jump, in, len, redirect target (word address).
- in_flush, in, 1, squash IF/ID without redirect.
- in_wr_en, in, 1, program-load write strobe.
- in_wr_addr, in, addr_w, program-load word address.
- in_wr_data, in, len, program-load data.
- out_instruction, out, len, IF/ID instruction register.
- out_pc_jump, out, len, IF/ID PC+1 register.
- out_pc, out, len, current PC register.
- out_valid, out, 1, IF/ID holds a real instruction.
- out_halted, out, 1, fetch stopped on HALT_WORD.

Function
REQ-003 The PC SHALL be a word address; memory index = PC[addr_w-1:0], so out-of-range PCs wrap.
REQ-004 Memory read SHALL be combinational from the array; IF/ID outputs SHALL be registered, so fetch-to-output latency is 1 cycle.
REQ-005 Per-edge priority, highest first:
- reset;
- in_enable=0: hold all state;
- in_pc_src=1: PC<=in_pc_jump; IF/ID<=NOP_WORD; out_valid<=0; out_halted<=0;
- in_flush=1: PC<=PC+1 unless halted; IF/ID<=NOP_WORD; out_valid<=0;
- in_stall=1: hold PC and IF/ID;
- normal: PC<=PC+1 unless halted; out_instruction<=mem[PC]; out_pc_jump<=PC+1; out_valid<=1.
REQ-006 in_pc_src SHALL override in_stall and out_halted in the same cycle.
REQ-007 PC+1 SHALL be computed modulo 2^len.
REQ-008 On a normal advance where mem[PC]==HALT_WORD:
- out_halted SHALL be set from the next cycle;
- the HALT word SHALL be latched into IF/ID with out_valid=1;
- PC SHALL stay at the HALT address.
REQ-009 While out_halted=1 and no redirect:
- PC SHALL hold;
- IF/ID SHALL load NOP_WORD with out_valid=0 on each enabled, unstalled cycle.
REQ-010 A HALT fetched in the same cycle as in_pc_src or in_flush SHALL NOT set out_halted.
REQ-011 in_wr_en SHALL write mem[in_wr_addr]<=in_wr_data at the edge, independent of in_enable, in_stall and out_halted.
REQ-012 Same-edge write and fetch at the same address SHALL return the old data to IF/ID.

Reset
REQ-013 On reset, these SHALL be cleared on the next edge, overriding all other inputs:
- PC=0, out_instruction=NOP_WORD, out_pc_jump=0, out_valid=0, out_halted=0.
REQ-014 Reset SHALL NOT clear memory contents.
REQ-015 Reset asserted mid-stall, mid-halt or mid-redirect SHALL give the REQ-013 state on the next edge.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Load mem[0..3]=0x11,0x22,0x33,HALT; release reset; enable=1 -> IF/ID 0x11/1, 0x22/2, 0x33/3, HALT/4; then out_halted=1, PC=3, out_valid=0.
- Stall at the cycle fetching PC=1 for 2 cycles -> out_instruction=0x11 held 2 extra cycles; PC stays 1.
- in_pc_src=1 with in_pc_jump=0x40 and in_stall=1 together -> next PC=0x40, out_valid=0, out_instruction=NOP_WORD.
- While halted, in_pc_src=1 with target 0 -> out_halted=0; fetch resumes at 0x11.
- HALT at PC 3 fetched with in_flush=1 -> no halt; PC=4.
- Write 0x99 to addr 5 while fetching PC=5 -> IF/ID gets the old word; a refetch after a redirect to 5 gets 0x99.
- enable=0 for 3 cycles -> all outputs frozen.
- PC=2^len-1 -> next PC wraps to 0.
